sr_latch_inercial_n: RTL and testbench

- Parametrised, clocked, multi-channel SR latch with a per-input inertial filter.
- Input pulses shorter than FILT clock cycles are swallowed, the synchronous counterpart of an inertial gate delay.
- Each channel's filtered S/R pair drives an SR state register whose S=R=1 resolution is selectable.
- Used wherever asynchronous set/reset requests must be de-glitched and latched inside a clocked datapath.

---
 rtl/sr_latch_inercial_n.sv | 178 +++++++++++++++++
 tb/tb_sr_latch_inercial_n.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_inercial_n.sv
// rtl/sr_latch_inercial_n.sv - multi-channel clocked SR latch with per-input inertial filter
//
// sr_inertial_filt
//   Passes a raw level only after it has been sampled identically on FILT
//   consecutive rising edges; shorter pulses are swallowed and flagged.
//   clk       in   rising-edge clock
//   reset_L   in   asynchronous active-low reset
//   i_raw     in   raw input bit
//   o_f       out  filtered level
//   o_glitch  out  one-cycle pulse: a shorter-than-FILT pulse was swallowed
//
// sr_latch_inercial_n
//   CH independent channels; each channel's s/r pair is de-glitched by two
//   sr_inertial_filt instances and then drives a registered SR state whose
//   S=R=1 resolution is selected by MODE (0 reset-dominant, 1 set-dominant,
//   2 hold, 3 forbidden/NOR emulation with sticky err).
//   clk       in   rising-edge clock
//   reset_L   in   asynchronous active-low reset
//   s         in   [CH] raw set requests
//   r         in   [CH] raw reset requests
//   clr_err   in   synchronous clear of all err bits
//   q         out  [CH] latch state
//   qb        out  [CH] complement of q (both 0 in the MODE 3 forbidden state)
//   glitch    out  [CH] swallowed-pulse indication, OR of s and r filters
//   err       out  [CH] sticky forbidden-state flag (MODE 3 only)

module sr_inertial_filt #(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic reset_L,
  input  logic i_raw,
  output logic o_f,
  output logic o_glitch
);

  localparam int CW = $clog2(FILT + 1);
  localparam logic [CW-1:0] CMAX = CW'(FILT - 1);

  logic          r_f;
  logic [CW-1:0] r_cnt;
  logic          r_glitch;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_f      <= 1'b0;
      r_cnt    <= '0;
      r_glitch <= 1'b0;
    end else begin
      r_glitch <= 1'b0;
      if (i_raw == r_f) begin
        // A nonzero count here means the raw input went back before the
        // filter committed: that pulse was swallowed.
        r_cnt    <= '0;
        r_glitch <= (r_cnt != '0);
      end else if (r_cnt == CMAX) begin
        r_f   <= i_raw;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_f      = r_f;
  assign o_glitch = r_glitch;

endmodule

module sr_latch_inercial_n #(
  parameter int CH   = 4,
  parameter int FILT = 3,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic [CH-1:0] s,
  input  logic [CH-1:0] r,
  input  logic          clr_err,
  output logic [CH-1:0] q,
  output logic [CH-1:0] qb,
  output logic [CH-1:0] glitch,
  output logic [CH-1:0] err
);

  logic [CH-1:0] w_s_f;
  logic [CH-1:0] w_r_f;
  logic [CH-1:0] w_glitch_s;
  logic [CH-1:0] w_glitch_r;

  logic [CH-1:0] r_q;
  logic [CH-1:0] r_qb;
  logic [CH-1:0] r_err;

  logic [CH-1:0] w_q_nxt;
  logic [CH-1:0] w_qb_nxt;
  logic [CH-1:0] w_err_nxt;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    sr_inertial_filt #(.FILT(FILT)) u_filt_s (
      .clk      (clk),
      .reset_L  (reset_L),
      .i_raw    (s[gi]),
      .o_f      (w_s_f[gi]),
      .o_glitch (w_glitch_s[gi])
    );

    sr_inertial_filt #(.FILT(FILT)) u_filt_r (
      .clk      (clk),
      .reset_L  (reset_L),
      .i_raw    (r[gi]),
      .o_f      (w_r_f[gi]),
      .o_glitch (w_glitch_r[gi])
    );
  end

  always_comb begin
    w_q_nxt   = r_q;
    w_qb_nxt  = r_qb;
    w_err_nxt = r_err;
    for (int i = 0; i < CH; i++) begin
      unique case ({w_s_f[i], w_r_f[i]})
        2'b10: begin
          w_q_nxt[i]  = 1'b1;
          w_qb_nxt[i] = 1'b0;
        end
        2'b01: begin
          w_q_nxt[i]  = 1'b0;
          w_qb_nxt[i] = 1'b1;
        end
        2'b11: begin
          if (MODE == 0) begin
            w_q_nxt[i]  = 1'b0;
            w_qb_nxt[i] = 1'b1;
          end else if (MODE == 1) begin
            w_q_nxt[i]  = 1'b1;
            w_qb_nxt[i] = 1'b0;
          end else if (MODE == 3) begin
            w_q_nxt[i]  = 1'b0;
            w_qb_nxt[i] = 1'b0;
          end
        end
        default: begin
          // Releasing both inputs together from the forbidden state would
          // make a real NOR latch oscillate; resolve to reset instead.
          if (!r_q[i] && !r_qb[i]) begin
            w_qb_nxt[i] = 1'b1;
          end
        end
      endcase

      // Setting wins over clearing when the forbidden pair is still present.
      if ((MODE == 3) && w_s_f[i] && w_r_f[i]) begin
        w_err_nxt[i] = 1'b1;
      end else if (clr_err) begin
        w_err_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_q   <= '0;
      r_qb  <= '1;
      r_err <= '0;
    end else begin
      r_q   <= w_q_nxt;
      r_qb  <= w_qb_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign q      = r_q;
  assign qb     = r_qb;
  assign err    = r_err;
  assign glitch = w_glitch_s | w_glitch_r;

endmodule

// File: tb/tb_sr_latch_inercial_n.sv
// tb/tb_sr_latch_inercial_n.sv - directed self-checking bench for sr_latch_inercial_n

module tb_sr_latch_inercial_n;

  logic       clk;
  logic       reset_L;
  logic [3:0] s;
  logic [3:0] r;
  logic       clr_err;

  logic [3:0] q0, qb0, g0, e0;
  logic [3:0] q1, qb1, g1, e1;
  logic [3:0] q2, qb2, g2, e2;
  logic [3:0] q3, qb3, g3, e3;
  logic [3:0] qf, qbf, gf, ef;

  int errors;
  int checks;

  sr_latch_inercial_n #(.CH(4), .FILT(3), .MODE(0)) u_m0 (
    .clk(clk), .reset_L(reset_L), .s(s), .r(r), .clr_err(clr_err),
    .q(q0), .qb(qb0), .glitch(g0), .err(e0));
  sr_latch_inercial_n #(.CH(4), .FILT(3), .MODE(1)) u_m1 (
    .clk(clk), .reset_L(reset_L), .s(s), .r(r), .clr_err(clr_err),
    .q(q1), .qb(qb1), .glitch(g1), .err(e1));
  sr_latch_inercial_n #(.CH(4), .FILT(3), .MODE(2)) u_m2 (
    .clk(clk), .reset_L(reset_L), .s(s), .r(r), .clr_err(clr_err),
    .q(q2), .qb(qb2), .glitch(g2), .err(e2));
  sr_latch_inercial_n #(.CH(4), .FILT(3), .MODE(3)) u_m3 (
    .clk(clk), .reset_L(reset_L), .s(s), .r(r), .clr_err(clr_err),
    .q(q3), .qb(qb3), .glitch(g3), .err(e3));
  sr_latch_inercial_n #(.CH(4), .FILT(1), .MODE(0)) u_f1 (
    .clk(clk), .reset_L(reset_L), .s(s), .r(r), .clr_err(clr_err),
    .q(qf), .qb(qbf), .glitch(gf), .err(ef));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    s = 4'b0000;
    r = 4'b0000;
    clr_err = 1'b0;
    tick();
    tick();
    checks++;
    if ({q0, qb0, g0, e0} !== {4'b0000, 4'b1111, 4'b0000, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state got q=%b qb=%b g=%b e=%b exp q=0000 qb=1111 g=0000 e=0000", q0, qb0, g0, e0);
    end
    reset_L = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({q0, qb0, g0, e0, q3, qb3, e3} !== {4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000}) begin
        errors++;
        $display("FAIL idle cycle %0d got q=%b qb=%b g=%b e=%b m3 q=%b qb=%b e=%b", i, q0, qb0, g0, e0, q3, qb3, e3);
      end
    end
  endtask

  task automatic test_set_reset();
    s = 4'b0001;
    tick();
    tick();
    tick();
    checks++;
    if (q0[0] !== 1'b0) begin
      errors++;
      $display("FAIL set_early got q0=%b exp 0", q0[0]);
    end
    s = 4'b0000;
    tick();
    checks++;
    if ({q0[0], qb0[0]} !== 2'b10) begin
      errors++;
      $display("FAIL set_k3 got q/qb=%b exp 10", {q0[0], qb0[0]});
    end
    tick();
    tick();
    tick();
    r = 4'b0001;
    tick();
    tick();
    tick();
    checks++;
    if (q0[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_early got q0=%b exp 1", q0[0]);
    end
    tick();
    checks++;
    if ({q0[0], qb0[0]} !== 2'b01) begin
      errors++;
      $display("FAIL reset_k3 got q/qb=%b exp 01", {q0[0], qb0[0]});
    end
    tick();
    r = 4'b0000;
    tick();
    tick();
    tick();
    checks++;
    if (g0 !== 4'b0000) begin
      errors++;
      $display("FAIL set_reset_noglitch got g=%b exp 0000", g0);
    end
  endtask

  task automatic test_glitch();
    logic seen;
    s = 4'b0010;
    tick();
    s = 4'b0000;
    tick();
    checks++;
    if (g0 !== 4'b0010) begin
      errors++;
      $display("FAIL glitch_w1 got g=%b exp 0010", g0);
    end
    tick();
    checks++;
    if ({g0, q0[1]} !== 5'b00000) begin
      errors++;
      $display("FAIL glitch_w1_after got g=%b q1=%b exp g=0000 q1=0", g0, q0[1]);
    end
    s = 4'b0010;
    tick();
    tick();
    s = 4'b0000;
    tick();
    checks++;
    if (g0 !== 4'b0010) begin
      errors++;
      $display("FAIL glitch_w2 got g=%b exp 0010", g0);
    end
    tick();
    checks++;
    if ({g0, q0[1]} !== 5'b00000) begin
      errors++;
      $display("FAIL glitch_w2_after got g=%b q1=%b exp g=0000 q1=0", g0, q0[1]);
    end
    seen = 1'b0;
    s = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | g0[1];
    end
    s = 4'b0000;
    tick();
    seen = seen | g0[1];
    checks++;
    if ({q0[1], seen} !== 2'b10) begin
      errors++;
      $display("FAIL pulse_w3 got q1=%b glitch_seen=%b exp q1=1 glitch_seen=0", q0[1], seen);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_mode_sweep();
    s = 4'b0100;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({q0[2], q1[2], q2[2], q3[2]} !== 4'b1111) begin
      errors++;
      $display("FAIL sweep_preset got q2 m0..m3=%b exp 1111", {q0[2], q1[2], q2[2], q3[2]});
    end
    r = 4'b0100;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({q0[2], qb0[2]} !== 2'b01) begin
      errors++;
      $display("FAIL mode0_both got q/qb=%b exp 01", {q0[2], qb0[2]});
    end
    checks++;
    if ({q1[2], qb1[2]} !== 2'b10) begin
      errors++;
      $display("FAIL mode1_both got q/qb=%b exp 10", {q1[2], qb1[2]});
    end
    checks++;
    if ({q2[2], qb2[2]} !== 2'b10) begin
      errors++;
      $display("FAIL mode2_both got q/qb=%b exp 10", {q2[2], qb2[2]});
    end
    checks++;
    if ({q3[2], qb3[2], e3} !== {2'b00, 4'b0100}) begin
      errors++;
      $display("FAIL mode3_both got q/qb=%b err=%b exp 00 err=0100", {q3[2], qb3[2]}, e3);
    end
    checks++;
    if ({e0, e1, e2} !== 12'h000) begin
      errors++;
      $display("FAIL err_other_modes got e0=%b e1=%b e2=%b exp 0", e0, e1, e2);
    end
  endtask

  task automatic test_mode3_exit();
    s = 4'b0000;
    r = 4'b0000;
    tick();
    tick();
    tick();
    checks++;
    if ({q3[2], qb3[2]} !== 2'b00) begin
      errors++;
      $display("FAIL m3_still_forbidden got q/qb=%b exp 00", {q3[2], qb3[2]});
    end
    tick();
    checks++;
    if ({q3[2], qb3[2], e3[2]} !== 3'b011) begin
      errors++;
      $display("FAIL m3_exit_00 got q/qb/err=%b exp 011", {q3[2], qb3[2], e3[2]});
    end
    checks++;
    if ({q2[2], qb2[2]} !== 2'b10) begin
      errors++;
      $display("FAIL m2_release_hold got q/qb=%b exp 10", {q2[2], qb2[2]});
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (e3 !== 4'b0000) begin
      errors++;
      $display("FAIL m3_clr_err got err=%b exp 0000", e3);
    end
    s = 4'b0100;
    r = 4'b0100;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({q3[2], qb3[2], e3[2]} !== 3'b001) begin
      errors++;
      $display("FAIL m3_reenter got q/qb/err=%b exp 001", {q3[2], qb3[2], e3[2]});
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (e3[2] !== 1'b1) begin
      errors++;
      $display("FAIL m3_set_wins got err=%b exp 1", e3[2]);
    end
    s = 4'b0000;
    r = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    s = 4'b1000;
    for (int i = 0; i < 4; i++) tick();
    s = 4'b0000;
    tick();
    tick();
    tick();
    s = 4'b1000;
    tick();
    tick();
    checks++;
    if (q0 !== 4'b1010) begin
      errors++;
      $display("FAIL pre_midreset got q=%b exp 1010", q0);
    end
    #3;
    reset_L = 1'b0;
    #1;
    checks++;
    if ({q0, qb0, g0, e3} !== {4'b0000, 4'b1111, 4'b0000, 4'b0000}) begin
      errors++;
      $display("FAIL async_reset got q=%b qb=%b g=%b e3=%b exp q=0000 qb=1111 g=0000 e3=0000", q0, qb0, g0, e3);
    end
    #1;
    reset_L = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (q0[3] !== 1'b0) begin
      errors++;
      $display("FAIL refilter_early got q3=%b exp 0", q0[3]);
    end
    tick();
    checks++;
    if ({q0[3], qb0[3]} !== 2'b10) begin
      errors++;
      $display("FAIL refilter_k3 got q/qb=%b exp 10", {q0[3], qb0[3]});
    end
  endtask

  task automatic test_back_to_back();
    s = 4'b0011;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (q0 !== 4'b1011) begin
      errors++;
      $display("FAIL multi_set got q=%b exp 1011", q0);
    end
    s = 4'b0000;
    r = 4'b1001;
    tick();
    tick();
    tick();
    checks++;
    if (q0 !== 4'b1011) begin
      errors++;
      $display("FAIL multi_early got q=%b exp 1011", q0);
    end
    tick();
    checks++;
    if ({q0, qb0} !== {4'b0010, 4'b1101}) begin
      errors++;
      $display("FAIL multi_reset got q=%b qb=%b exp q=0010 qb=1101", q0, qb0);
    end
    r = 4'b0000;
  endtask

  task automatic test_filt1();
    logic [3:0] seen;
    s = 4'b0000;
    r = 4'b0000;
    #2;
    reset_L = 1'b0;
    #1;
    reset_L = 1'b1;
    seen = 4'b0000;
    s = 4'b0001;
    tick();
    seen = seen | gf;
    checks++;
    if (qf[0] !== 1'b0) begin
      errors++;
      $display("FAIL f1_edge1 got q0=%b exp 0", qf[0]);
    end
    tick();
    seen = seen | gf;
    checks++;
    if ({qf[0], qbf[0]} !== 2'b10) begin
      errors++;
      $display("FAIL f1_edge2 got q/qb=%b exp 10", {qf[0], qbf[0]});
    end
    s = 4'b0011;
    tick();
    seen = seen | gf;
    s = 4'b0001;
    tick();
    seen = seen | gf;
    checks++;
    if (qf[1] !== 1'b1) begin
      errors++;
      $display("FAIL f1_pulse_set got q1=%b exp 1", qf[1]);
    end
    r = 4'b0010;
    tick();
    seen = seen | gf;
    r = 4'b0000;
    tick();
    seen = seen | gf;
    checks++;
    if ({qf[1], seen} !== 5'b00000) begin
      errors++;
      $display("FAIL f1_pulse_reset got q1=%b glitch_seen=%b exp q1=0 glitch_seen=0000", qf[1], seen);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_L = 1'b0;
    s = 4'b0000;
    r = 4'b0000;
    clr_err = 1'b0;
    test_reset();
    test_set_reset();
    test_glitch();
    test_mode_sweep();
    test_mode3_exit();
    test_reset_mid();
    test_back_to_back();
    test_filt1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
